// File: rtl/nco_seq.sv
// nco_seq: NCO load sequencer and phase accumulator for the Costas loop carrier path.
// After reset release or a restart it loads the base frequency word, then the start
// phase, then settles. In RUN it accumulates phase modulo 2^PHASE_W. Each step is the
// base frequency plus a signed loop-filter correction that is clamped to +/-FREQ_LIM.
// Optional feature macro: NCO_DITHER_EN adds a 16-bit LFSR that dithers each step by 0..15.
module nco_seq #(
   parameter int unsigned        PHASE_W    = 32,
   parameter int unsigned        OUT_W      = 8,
   parameter int unsigned        CORR_W     = 24,
   parameter logic [PHASE_W-1:0] FREQ_INIT  = PHASE_W'(32'h2000_0000),
   parameter logic [PHASE_W-1:0] PHASE_INIT = PHASE_W'(32'hC000_0000),
   parameter logic [PHASE_W-1:0] FREQ_LIM   = PHASE_W'(32'h0010_0000)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     restart,
   input  logic                     corr_valid,
   input  logic signed [CORR_W-1:0] corr,
   output logic                     corr_ready,
   output logic                     valid,
   output logic [PHASE_W-1:0]       phase_out,
   output logic [OUT_W-1:0]         phase_trunc,
   output logic                     busy
);

   localparam int unsigned LFSR_W = 16;
   localparam int unsigned DITH_W = 4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_FREQ,
      S_LOAD_PHASE,
      S_SETTLE,
      S_RUN
   } state_t;

   state_t                     state_q, state_d;
   logic                       pend_q, pend_d;
   logic [PHASE_W-1:0]         freq_q;
   logic [PHASE_W-1:0]         acc_q;
   logic signed [CORR_W-1:0]   corr_q;

   logic                       accept_c;
   logic signed [PHASE_W-1:0]  corr_ext_c;
   logic signed [PHASE_W-1:0]  lim_pos_c;
   logic signed [PHASE_W-1:0]  lim_neg_c;
   logic signed [PHASE_W-1:0]  clamp_c;
   logic signed [CORR_W-1:0]   corr_clamp_c;
   logic signed [PHASE_W-1:0]  corr_sext_c;
   logic [PHASE_W-1:0]         step_c;

`ifdef NCO_DITHER_EN
   logic [LFSR_W-1:0]          lfsr_q;
   logic                       lfsr_fb_c;

   // Fibonacci feedback from taps 16,14,13,11
   assign lfsr_fb_c = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

   // Dither LFSR advances once per RUN cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr_q <= LFSR_W'(16'hACE1);
      end else if (state_q == S_RUN) begin
         lfsr_q <= {lfsr_q[LFSR_W-2:0], lfsr_fb_c};
      end
   end
`endif

   // Next-state decode; restart from any non-IDLE state re-enters the load sequence
   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      case (state_q)
         S_IDLE: begin
            if (pend_q) begin
               state_d = S_LOAD_FREQ;
               pend_d  = 1'b0;
            end else if (restart) begin
               pend_d  = 1'b1;
            end
         end
         S_LOAD_FREQ:  state_d = S_LOAD_PHASE;
         S_LOAD_PHASE: state_d = S_SETTLE;
         S_SETTLE:     state_d = S_RUN;
         S_RUN:        state_d = S_RUN;
         default:      state_d = S_IDLE;
      endcase
      if (restart && (state_q != S_IDLE)) begin
         state_d = S_LOAD_FREQ;
      end
   end

   // Signed clamp of the incoming correction and the per-cycle phase increment
   always_comb begin
      accept_c     = corr_valid & corr_ready & ~restart;
      corr_ext_c   = PHASE_W'(corr);
      lim_pos_c    = $signed(FREQ_LIM);
      lim_neg_c    = -lim_pos_c;
      clamp_c      = corr_ext_c;
      if (corr_ext_c > lim_pos_c) begin
         clamp_c = lim_pos_c;
      end else if (corr_ext_c < lim_neg_c) begin
         clamp_c = lim_neg_c;
      end
      corr_clamp_c = CORR_W'(clamp_c);
      corr_sext_c  = PHASE_W'(corr_q);
`ifdef NCO_DITHER_EN
      step_c       = freq_q + $unsigned(corr_sext_c) + PHASE_W'(lfsr_q[DITH_W-1:0]);
`else
      step_c       = freq_q + $unsigned(corr_sext_c);
`endif
   end

   // State register, registered status outputs and accumulator datapath
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         pend_q     <= 1'b1;
         freq_q     <= '0;
         acc_q      <= '0;
         corr_q     <= '0;
         valid      <= 1'b0;
         busy       <= 1'b0;
         corr_ready <= 1'b0;
      end else begin
         state_q    <= state_d;
         pend_q     <= pend_d;
         valid      <= (state_d == S_RUN);
         corr_ready <= (state_d == S_RUN);
         busy       <= (state_d == S_LOAD_FREQ) || (state_d == S_LOAD_PHASE) ||
                       (state_d == S_SETTLE);
         case (state_q)
            S_LOAD_FREQ: begin
               freq_q <= FREQ_INIT;
               corr_q <= '0;
            end
            S_LOAD_PHASE: acc_q <= PHASE_INIT;
            S_RUN: begin
               acc_q <= acc_q + step_c;
               if (accept_c) begin
                  corr_q <= corr_clamp_c;
               end
            end
            default: ;
         endcase
      end
   end

   assign phase_out   = acc_q;
   assign phase_trunc = acc_q[PHASE_W-1 -: OUT_W];

`ifndef NCO_DITHER_EN
   logic unused_c;
   assign unused_c = ^{LFSR_W[0], DITH_W[0]};
`endif

endmodule

// File: tb/tb_nco_seq.sv
// tb_nco_seq: directed self-checking bench for nco_seq with default parameters.
// With NCO_DITHER_EN the run-time steps are allowed to exceed nominal by 0..15.
`timescale 1ns/1ps
module tb_nco_seq;

`ifdef NCO_DITHER_EN
   localparam logic [31:0] TOL = 32'd15;
`else
   localparam logic [31:0] TOL = 32'd0;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic              restart;
   logic              corr_valid;
   logic signed [23:0] corr;
   logic              corr_ready;
   logic              valid;
   logic [31:0]       phase_out;
   logic [7:0]        phase_trunc;
   logic              busy;

   int errors = 0;
   int checks = 0;

   nco_seq dut (
      .clk         (clk),
      .rst         (rst),
      .restart     (restart),
      .corr_valid  (corr_valid),
      .corr        (corr),
      .corr_ready  (corr_ready),
      .valid       (valid),
      .phase_out   (phase_out),
      .phase_trunc (phase_trunc),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Advance one edge and return the phase increment it produced
   task automatic measure_step(output logic [31:0] step);
      logic [31:0] p;
      p = phase_out;
      tick();
      step = phase_out - p;
   endtask

   task automatic test_reset();
      rst = 1'b1; restart = 1'b0; corr_valid = 1'b0; corr = '0;
      #3;
      checks++;
      if ({valid, busy, corr_ready, phase_out, phase_trunc} !== 43'd0) begin
         errors++;
         $display("FAIL reset_outputs: got v=%0b b=%0b r=%0b ph=%h tr=%h, want all 0",
                  valid, busy, corr_ready, phase_out, phase_trunc);
      end
      tick();
      rst = 1'b0;
   endtask

   // Checks E1..E4 and the first three RUN steps after reset release or restart
   task automatic test_startup(input string tag);
      logic [31:0] exp_ph [4];
      logic [7:0]  exp_tr [4];
      exp_ph = '{32'hC000_0000, 32'hE000_0000, 32'h0000_0000, 32'h2000_0000};
      exp_tr = '{8'hC0, 8'hE0, 8'h00, 8'h20};
      for (int e = 1; e <= 3; e++) begin
         tick();
         checks++;
         if (busy !== 1'b1 || valid !== 1'b0 || corr_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy_E%0d: got b=%0b v=%0b r=%0b, want b=1 v=0 r=0",
                     tag, e, busy, valid, corr_ready);
         end
      end
      checks++;
      if (phase_out !== 32'hC000_0000) begin
         errors++;
         $display("FAIL %s_phase_E3: got %h, want C0000000", tag, phase_out);
      end
      tick();
      checks++;
      if (valid !== 1'b1 || busy !== 1'b0 || corr_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s_run_E4: got v=%0b b=%0b r=%0b, want v=1 b=0 r=1",
                  tag, valid, busy, corr_ready);
      end
      for (int i = 0; i < 4; i++) begin
         if (i > 0) tick();
         checks++;
         if ((phase_out - exp_ph[i]) > TOL * 32'(i)) begin
            errors++;
            $display("FAIL %s_phase_%0d: got %h, want %h", tag, i, phase_out, exp_ph[i]);
         end
         checks++;
         if (phase_trunc !== exp_tr[i]) begin
            errors++;
            $display("FAIL %s_trunc_%0d: got %h, want %h", tag, i, phase_trunc, exp_tr[i]);
         end
      end
   endtask

   task automatic test_correction();
      logic [31:0] s;
      corr = 24'sh000100; corr_valid = 1'b1;
      checks++;
      if (corr_ready !== 1'b1) begin
         errors++;
         $display("FAIL corr_ready_run: got %0b, want 1", corr_ready);
      end
      measure_step(s);
      corr_valid = 1'b0;
      checks++;
      if ((s - 32'h2000_0000) > TOL) begin
         errors++;
         $display("FAIL corr_latency: got step %h, want 20000000", s);
      end
      for (int k = 0; k < 2; k++) begin
         measure_step(s);
         checks++;
         if ((s - 32'h2000_0100) > TOL) begin
            errors++;
            $display("FAIL corr_pos_%0d: got step %h, want 20000100", k, s);
         end
      end
      corr = -24'sh000100; corr_valid = 1'b1;
      tick();
      corr_valid = 1'b0;
      measure_step(s);
      checks++;
      if ((s - 32'h1FFF_FF00) > TOL) begin
         errors++;
         $display("FAIL corr_neg: got step %h, want 1FFFFF00", s);
      end
   endtask

   task automatic test_saturation();
      logic [23:0] vin  [7];
      logic [31:0] vexp [7];
      logic [31:0] s;
      vin  = '{24'h7FFFFF, 24'h800000, 24'h100000, 24'h100001,
               24'hF00000, 24'hEFFFFF, 24'h000000};
      vexp = '{32'h2010_0000, 32'h1FF0_0000, 32'h2010_0000, 32'h2010_0000,
               32'h1FF0_0000, 32'h1FF0_0000, 32'h2000_0000};
      for (int i = 0; i < 7; i++) begin
         corr = vin[i]; corr_valid = 1'b1;
         tick();
         corr_valid = 1'b0;
         measure_step(s);
         checks++;
         if ((s - vexp[i]) > TOL) begin
            errors++;
            $display("FAIL sat_%h: got step %h, want %h", vin[i], s, vexp[i]);
         end
      end
   endtask

   task automatic test_restart_with_corr();
      logic [31:0] s;
      corr = 24'sh7FFFFF; corr_valid = 1'b1;
      tick();
      corr = 24'sh000100; restart = 1'b1;
      tick();
      restart = 1'b0; corr_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         if (c > 0) tick();
         checks++;
         if (busy !== 1'b1 || valid !== 1'b0) begin
            errors++;
            $display("FAIL restart_busy_%0d: got b=%0b v=%0b, want b=1 v=0", c, busy, valid);
         end
      end
      tick();
      checks++;
      if (valid !== 1'b1 || busy !== 1'b0 || phase_out !== 32'hC000_0000) begin
         errors++;
         $display("FAIL restart_resume: got v=%0b b=%0b ph=%h, want v=1 b=0 ph=C0000000",
                  valid, busy, phase_out);
      end
      measure_step(s);
      checks++;
      if ((s - 32'h2000_0000) > TOL) begin
         errors++;
         $display("FAIL restart_step: got %h, want 20000000", s);
      end
   endtask

   task automatic test_async_reset();
      tick();
      #1 rst = 1'b1;
      #1;
      checks++;
      if ({valid, busy, corr_ready, phase_out} !== 35'd0) begin
         errors++;
         $display("FAIL async_reset: got v=%0b b=%0b r=%0b ph=%h, want all 0",
                  valid, busy, corr_ready, phase_out);
      end
      tick();
      tick();
      rst = 1'b0;
      test_startup("rerun");
   endtask

   task automatic test_corr_outside_run();
      logic [31:0] s;
      corr = 24'sh000100; corr_valid = 1'b1; restart = 1'b1;
      tick();
      restart = 1'b0;
      for (int c = 0; c < 3; c++) begin
         if (c > 0) tick();
         checks++;
         if (corr_ready !== 1'b0) begin
            errors++;
            $display("FAIL outside_ready_%0d: got %0b, want 0", c, corr_ready);
         end
      end
      tick();
      corr_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         measure_step(s);
         checks++;
         if ((s - 32'h2000_0000) > TOL) begin
            errors++;
            $display("FAIL outside_step_%0d: got %h, want 20000000", k, s);
         end
      end
   endtask

   initial begin
      test_reset();
      test_startup("boot");
      test_correction();
      test_saturation();
      test_restart_with_corr();
      test_async_reset();
      test_corr_outside_run();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
